div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester (bit0 = port 0, bit1 = port 1) divide request.
REQ-005 req_ready  out  2  per-requester acceptance; a request is taken when req_valid[i] & req_ready[i].
REQ-006 req_signed  in  2  per-requester signed-divide select.
REQ-007 req_a  in  2*WIDTH  dividends; port i at [i*WIDTH +: WIDTH].
REQ-008 req_b  in  2*WIDTH  divisors, same packing as req_a.
REQ-009 flush  in  1  pipeline flush; kills the pending operation.
REQ-010 div_start  out  1  one-cycle start pulse to the shared unsigned iterative divider.
REQ-011 div_abort  out  1  one-cycle abort pulse to the divider.
REQ-012 div_a, div_b  out  WIDTH each  unsigned operand magnitudes to the divider.
REQ-013 div_done  in  1  divider completion pulse; div_quot, div_rem (in, WIDTH each) are valid in that cycle.
REQ-014 res_valid  out  1  result available; res_ready  in  1  consumer accepts.
REQ-015 res_id  out  1  index of the requester owning the result; res_quot, res_rem  out  WIDTH each.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 States: IDLE, RUN, HOLD.
REQ-018 IDLE: req_ready[i] = 1 only for the granted port and only when flush = 0; all other cycles req_ready = 0.
REQ-019 Accept in IDLE: latch id, signed flag and sign bits; div_a/div_b = magnitudes (two's-complement negate if signed and MSB set, else raw); next state RUN.
REQ-020 RUN, first cycle: div_start = 1 for exactly one cycle; div_a/div_b held stable for the whole of RUN.
REQ-021 RUN, div_done = 1: register sign-corrected result; next state HOLD.
REQ-022 Sign correction: quotient negated if signed and sign(a) != sign(b); remainder negated if signed and a negative.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF: res_quot = 0x80000000, res_rem = 0 (wrap, no trap).
REQ-024 Divisor zero at accept: no div_start; next state HOLD directly with res_quot = all ones, res_rem = dividend unchanged.
REQ-025 HOLD: res_valid = 1 with results stable until res_valid & res_ready, then IDLE next cycle; no same-cycle re-accept.
REQ-026 flush in RUN: div_abort = 1 that cycle, next state IDLE, no res_valid; flush coinciding with div_done also wins (result dropped).
REQ-027 flush in HOLD: res_valid drops next cycle, next state IDLE; flush overrides a same-cycle res_ready only in that the transfer SHALL still count as discarded.
REQ-028 Arbitration when both req_valid set in IDLE: see Configuration; a single requester is always granted.

Reset
REQ-029 reset = 1 SHALL force IDLE, priority pointer to port 0, all outputs 0 (req_ready, div_start, div_abort, div_a, div_b, res_*, busy) next cycle.
REQ-030 reset mid-RUN SHALL NOT assert div_abort; the divider shares the same reset.

Configuration
REQ-031 Macro DIV_SCHED_RR_EN defined: round-robin; after each accept the priority pointer moves to the other port.
REQ-032 DIV_SCHED_RR_EN undefined: fixed priority, port 0 always wins; no pointer state.

Verification
REQ-033 Port0 unsigned 100/7 -> div_start 1 cycle after accept; after div_done res_quot = 14, res_rem = 2, res_id = 0.
REQ-034 Port1 signed -7/2 (0xFFFFFFF9/2) -> div_a = 7, div_b = 2; divider returns 3,1 -> res_quot = 0xFFFFFFFD, res_rem = 0xFFFFFFFF, res_id = 1.
REQ-035 Port0 5/0 -> no div_start; res_valid 1 cycle after accept, res_quot = 0xFFFFFFFF, res_rem = 5.
REQ-036 Both ports valid for 3 consecutive operations -> RR_EN: grants 0,1,0; without: 0,0,0.
REQ-037 flush 2 cycles after div_start -> div_abort pulse, busy = 0 next cycle, res_valid never asserted; new request then accepted.
REQ-038 res_ready held low 5 cycles in HOLD -> res_* stable, req_ready = 0 throughout; reset mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/div_sched_if.sv
// Handshake bundle for div_sched: two requester ports, shared-divider link, result port.
interface div_sched_if #(parameter int WIDTH = 32) ();
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [1:0]         req_signed;
   logic [2*WIDTH-1:0] req_a;
   logic [2*WIDTH-1:0] req_b;
   logic               flush;
   logic               div_start;
   logic               div_abort;
   logic [WIDTH-1:0]   div_a;
   logic [WIDTH-1:0]   div_b;
   logic               div_done;
   logic [WIDTH-1:0]   div_quot;
   logic [WIDTH-1:0]   div_rem;
   logic               res_valid;
   logic               res_ready;
   logic               res_id;
   logic [WIDTH-1:0]   res_quot;
   logic [WIDTH-1:0]   res_rem;
   logic               busy;

   modport slave (
      input  req_valid, req_signed, req_a, req_b, flush,
             div_done, div_quot, div_rem, res_ready,
      output req_ready, div_start, div_abort, div_a, div_b,
             res_valid, res_id, res_quot, res_rem, busy
   );

   modport master (
      output req_valid, req_signed, req_a, req_b, flush,
             div_done, div_quot, div_rem, res_ready,
      input  req_ready, div_start, div_abort, div_a, div_b,
             res_valid, res_id, res_quot, res_rem, busy
   );
endinterface

// File: rtl/div_sched.sv
// Two-port scheduler in front of a shared unsigned iterative divider, with sign handling.
// Optional macro DIV_SCHED_RR_EN: round-robin arbitration (default build: port 0 fixed priority).
module div_sched #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   div_sched_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]       r_state;
   logic             r_id;
   logic             r_neg_a;
   logic             r_neg_b;
   logic             r_start;
   logic [WIDTH-1:0] r_div_a;
   logic [WIDTH-1:0] r_div_b;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;

   logic [1:0]       w_grant;
   logic [1:0]       w_ready;
   logic             w_accept;
   logic             w_gid;
   logic             w_sgn;
   logic             w_neg_a;
   logic             w_neg_b;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

`ifdef DIV_SCHED_RR_EN
   logic r_ptr;

   always_comb begin
      w_grant = bus.req_valid;
      if (bus.req_valid == 2'b11)
         w_grant = r_ptr ? 2'b10 : 2'b01;
   end
`else
   always_comb begin
      w_grant = 2'b00;
      if (bus.req_valid[0])
         w_grant = 2'b01;
      else if (bus.req_valid[1])
         w_grant = 2'b10;
   end
`endif

   assign w_ready  = (r_state == S_IDLE && !bus.flush && !reset) ? w_grant : 2'b00;
   assign w_accept = |(w_ready & bus.req_valid);
   assign w_gid    = w_grant[1];

   assign w_a     = w_gid ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
   assign w_b     = w_gid ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
   assign w_sgn   = bus.req_signed[w_gid];
   // Sign bits are stored already qualified by the signed flag, so unsigned ops never fix up.
   assign w_neg_a = w_sgn & w_a[WIDTH-1];
   assign w_neg_b = w_sgn & w_b[WIDTH-1];
   assign w_mag_a = w_neg_a ? -w_a : w_a;
   assign w_mag_b = w_neg_b ? -w_b : w_b;

   // MIN/-1 falls out naturally: the negated magnitude wraps back to MIN.
   assign w_q_fix = (r_neg_a ^ r_neg_b) ? -bus.div_quot : bus.div_quot;
   assign w_r_fix = r_neg_a ? -bus.div_rem : bus.div_rem;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_id    <= 1'b0;
         r_neg_a <= 1'b0;
         r_neg_b <= 1'b0;
         r_start <= 1'b0;
         r_div_a <= '0;
         r_div_b <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
`ifdef DIV_SCHED_RR_EN
         r_ptr   <= 1'b0;
`endif
      end else begin
         r_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_id    <= w_gid;
                  r_neg_a <= w_neg_a;
                  r_neg_b <= w_neg_b;
                  r_div_a <= w_mag_a;
                  r_div_b <= w_mag_b;
`ifdef DIV_SCHED_RR_EN
                  r_ptr   <= ~w_gid;
`endif
                  // Divide-by-zero never reaches the divider.
                  if (w_b == '0) begin
                     r_quot  <= '1;
                     r_rem   <= w_a;
                     r_state <= S_HOLD;
                  end else begin
                     r_start <= 1'b1;
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (bus.flush) begin
                  r_state <= S_IDLE;
               end else if (bus.div_done) begin
                  r_quot  <= w_q_fix;
                  r_rem   <= w_r_fix;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (bus.flush || bus.res_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.div_start = r_start;
   assign bus.div_abort = (r_state == S_RUN) && bus.flush && !reset;
   assign bus.div_a     = r_div_a;
   assign bus.div_b     = r_div_b;
   assign bus.res_valid = (r_state == S_HOLD);
   assign bus.res_id    = r_id;
   assign bus.res_quot  = r_quot;
   assign bus.res_rem   = r_rem;
   assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: behavioural divider, vector table, corner sequences, random ops vs model.
module tb_div_sched;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   div_sched_if #(.WIDTH(W)) bus ();
   div_sched #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_chk = 0;
   int n_err = 0;

   // Divider stand-in with programmable latency.
   int unsigned      lat_cfg = 3;
   logic             m_busy = 1'b0;
   int unsigned      m_cnt = 0;
   logic             m_done = 1'b0;
   logic [W-1:0]     m_q = '0;
   logic [W-1:0]     m_r = '0;
   assign bus.div_done = m_done;
   assign bus.div_quot = m_q;
   assign bus.div_rem  = m_r;

   always @(posedge clk) begin
      m_done <= 1'b0;
      if (reset || bus.div_abort) begin
         m_busy <= 1'b0;
      end else if (bus.div_start) begin
         m_busy <= 1'b1;
         m_cnt  <= lat_cfg;
         m_q    <= (bus.div_b == '0) ? '1 : bus.div_a / bus.div_b;
         m_r    <= (bus.div_b == '0) ? bus.div_a : bus.div_a % bus.div_b;
      end else if (m_busy) begin
         if (m_cnt == 0) begin
            m_done <= 1'b1;
            m_busy <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   int n_start = 0;
   int n_abort = 0;
   int n_rv = 0;
   always @(negedge clk) begin
      if (bus.div_start) n_start++;
      if (bus.div_abort) n_abort++;
      if (bus.res_valid) n_rv++;
   end

   typedef struct {
      int           port;
      bit           sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
      longint sa, sb;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = W'(sa / sb);
         r = W'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_in();
      bus.req_valid  = 2'b00;
      bus.req_signed = 2'b00;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.flush      = 1'b0;
      bus.res_ready  = 1'b0;
   endtask

   // Presents one request and returns just after the accepting edge.
   task automatic issue(input int p, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output bit ok);
      ok = 1'b0;
      bus.req_valid     = 2'b00;
      bus.req_valid[p]  = 1'b1;
      bus.req_signed[p] = s;
      bus.req_a[p*W +: W] = a;
      bus.req_b[p*W +: W] = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         if (bus.req_ready[p]) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.req_valid = 2'b00;
   endtask

   task automatic collect(output logic [W-1:0] q, output logic [W-1:0] r, output bit id,
                          output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (bus.res_valid) ok = 1'b1;
         else cyc();
      end
      q = bus.res_quot;
      r = bus.res_rem;
      id = bus.res_id;
      bus.res_ready = 1'b1;
      cyc();
      bus.res_ready = 1'b0;
   endtask

   task automatic run_op(input string nm, input int p, input bit s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er);
      bit ok, id;
      logic [W-1:0] q, r;
      issue(p, s, a, b, ok);
      chk({nm, " accept"}, 64'(ok), 64'd1);
      collect(q, r, id, ok);
      chk({nm, " res_valid"}, 64'(ok), 64'd1);
      chk({nm, " quot"}, 64'(q), 64'(eq));
      chk({nm, " rem"}, 64'(r), 64'(er));
      chk({nm, " id"}, 64'(id), 64'(p));
   endtask

   vec_t tbl [9];

   initial begin
      bit ok, id;
      bit g [3];
      bit eg [3];
      logic [W-1:0] q, r, a, b;
      int s0, a0, rv0, p, sel;
      bit s;

      tbl[0] = '{0, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
      tbl[1] = '{1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
      tbl[2] = '{0, 1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
      tbl[3] = '{1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
      tbl[4] = '{0, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1};
      tbl[5] = '{1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
      tbl[6] = '{0, 1'b1, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF8};
      tbl[7] = '{1, 1'b1, 32'hFFFF_FFF7,  32'hFFFF_FFFD,  32'd3,          32'd0};
      tbl[8] = '{0, 1'b1, 32'hFFFF_FFF6,  32'hFFFF_FFFD,  32'd3,          32'hFFFF_FFFF};

      idle_in();
      reset = 1'b1;
      cyc(3);
      chk("reset busy",      64'(bus.busy), 64'd0);
      chk("reset res_valid", 64'(bus.res_valid), 64'd0);
      chk("reset div_start", 64'(bus.div_start), 64'd0);
      chk("reset req_ready", 64'(bus.req_ready), 64'd0);
      chk("reset div_ab",    {bus.div_a, bus.div_b}, 64'd0);
      reset = 1'b0;
      cyc();

      // Flush gates acceptance in IDLE.
      bus.req_valid = 2'b01;
      bus.flush = 1'b1;
      #1;
      chk("flush idle ready", 64'(bus.req_ready), 64'd0);
      bus.flush = 1'b0;
      #1;
      chk("idle ready", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 2'b00;
      cyc();

      // Start pulse timing and operand hold for 100/7.
      lat_cfg = 4;
      issue(0, 1'b0, 32'd100, 32'd7, ok);
      chk("t accept", 64'(ok), 64'd1);
      chk("t div_start", 64'(bus.div_start), 64'd1);
      chk("t div_ab", {bus.div_a, bus.div_b}, {32'd100, 32'd7});
      chk("t busy", 64'(bus.busy), 64'd1);
      cyc();
      chk("t start one cycle", 64'(bus.div_start), 64'd0);
      chk("t div_ab hold", {bus.div_a, bus.div_b}, {32'd100, 32'd7});
      collect(q, r, id, ok);
      chk("t result", {q, r}, {32'd14, 32'd2});

      // Signed operand magnitudes reach the divider.
      issue(1, 1'b1, 32'hFFFF_FFF9, 32'd2, ok);
      chk("s div_ab", {bus.div_a, bus.div_b}, {32'd7, 32'd2});
      collect(q, r, id, ok);
      chk("s result", {q, r}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});

      for (int i = 0; i < 9; i++) begin
         lat_cfg = i % 4;
         run_op($sformatf("vec%0d", i), tbl[i].port, tbl[i].sgn, tbl[i].a, tbl[i].b,
                tbl[i].q, tbl[i].r);
      end

      // Divide by zero skips the divider entirely.
      s0 = n_start;
      issue(0, 1'b0, 32'd5, 32'd0, ok);
      chk("dz res_valid now", 64'(bus.res_valid), 64'd1);
      collect(q, r, id, ok);
      chk("dz result", {q, r}, {32'hFFFF_FFFF, 32'd5});
      chk("dz no start", 64'(n_start - s0), 64'd0);

      // Arbitration with both ports asserted for three operations.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      lat_cfg = 2;
      bus.req_a = {32'd9, 32'd9};
      bus.req_b = {32'd3, 32'd3};
      bus.req_valid = 2'b11;
`ifdef DIV_SCHED_RR_EN
      eg = '{1'b0, 1'b1, 1'b0};
`else
      eg = '{1'b0, 1'b0, 1'b0};
`endif
      for (int k = 0; k < 3; k++) begin
         ok = 1'b0;
         for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (bus.req_ready != 2'b00) ok = 1'b1;
            else cyc();
         end
         g[k] = bus.req_ready[1];
         chk($sformatf("arb%0d grant", k), 64'(g[k]), 64'(eg[k]));
         cyc();
         ok = 1'b0;
         for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.res_valid) ok = 1'b1;
            else cyc();
         end
         chk($sformatf("arb%0d res", k), 64'(ok), 64'd1);
         chk($sformatf("arb%0d id", k), 64'(bus.res_id), 64'(eg[k]));
         bus.res_ready = 1'b1;
         cyc();
         bus.res_ready = 1'b0;
      end
      idle_in();
      cyc();

      // Flush two cycles after the start pulse.
      lat_cfg = 10;
      a0 = n_abort;
      issue(1, 1'b0, 32'd50, 32'd5, ok);
      cyc(2);
      bus.flush = 1'b1;
      #1;
      chk("fl abort", 64'(bus.div_abort), 64'd1);
      cyc();
      bus.flush = 1'b0;
      chk("fl busy", 64'(bus.busy), 64'd0);
      rv0 = n_rv;
      cyc(15);
      chk("fl no res_valid", 64'(n_rv - rv0), 64'd0);
      chk("fl abort count", 64'(n_abort - a0), 64'd1);
      lat_cfg = 1;
      run_op("fl next", 1, 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

      // Flush landing on the done pulse drops the result.
      lat_cfg = 2;
      issue(0, 1'b0, 32'd77, 32'd7, ok);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         if (bus.div_done) ok = 1'b1;
         else cyc();
      end
      chk("fd done seen", 64'(ok), 64'd1);
      bus.flush = 1'b1;
      #1;
      chk("fd abort", 64'(bus.div_abort), 64'd1);
      cyc();
      bus.flush = 1'b0;
      chk("fd dropped", {63'd0, bus.res_valid | bus.busy}, 64'd0);

      // Flush in HOLD with res_ready.
      issue(0, 1'b0, 32'd9, 32'd0, ok);
      chk("fh hold", 64'(bus.res_valid), 64'd1);
      bus.flush = 1'b1;
      bus.res_ready = 1'b1;
      cyc();
      bus.flush = 1'b0;
      bus.res_ready = 1'b0;
      chk("fh dropped", {63'd0, bus.res_valid | bus.busy}, 64'd0);

      // Consumer stall in HOLD.
      lat_cfg = 1;
      issue(0, 1'b0, 32'd1000, 32'd33, ok);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         if (bus.res_valid) ok = 1'b1;
         else cyc();
      end
      chk("st hold", 64'(ok), 64'd1);
      bus.req_valid = 2'b11;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("st%0d res", i), {bus.res_quot, bus.res_rem}, {32'd30, 32'd10});
         chk($sformatf("st%0d ready", i), {62'd0, bus.req_ready}, 64'd0);
         chk($sformatf("st%0d valid", i), 64'(bus.res_valid), 64'd1);
         cyc();
      end
      bus.req_valid = 2'b00;
      bus.res_ready = 1'b1;
      cyc();
      bus.res_ready = 1'b0;
      chk("st idle", 64'(bus.busy), 64'd0);

      // Reset while the divider is running.
      lat_cfg = 20;
      a0 = n_abort;
      issue(1, 1'b1, 32'hFFFF_FF00, 32'd3, ok);
      cyc(2);
      reset = 1'b1;
      #1;
      chk("rr no abort", 64'(bus.div_abort), 64'd0);
      cyc();
      chk("rr ctl", {58'd0, bus.req_ready, bus.div_start, bus.div_abort, bus.res_valid,
                     bus.res_id, bus.busy}, 64'd0);
      chk("rr div_ab", {bus.div_a, bus.div_b}, 64'd0);
      chk("rr res", {bus.res_quot, bus.res_rem}, 64'd0);
      chk("rr abort count", 64'(n_abort - a0), 64'd0);
      reset = 1'b0;
      cyc();

      for (int i = 0; i < 40; i++) begin
         p = int'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         sel = int'($urandom_range(0, 9));
         if (sel == 0) b = '0;
         else if (sel == 1) begin
            a = 32'h8000_0000;
            b = '1;
         end else if (sel < 5) b = W'($urandom_range(1, 20));
         else b = $urandom;
         lat_cfg = $urandom_range(0, 6);
         ref_div(s, a, b, q, r);
         run_op($sformatf("rnd%0d", i), p, s, a, b, q, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
